// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between N_REQ byte producers
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [GW-1:0]      grant_id,
  output logic [7:0]         tx_din,
  output logic               tx_wr_en,
  input  logic               tx_busy,
  output logic               busy,
  output logic               err_timeout
);

  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          found;
  logic [GW-1:0] win;
  int            idx;

  // First pending requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      ack         <= '0;
      grant_id    <= '0;
      tx_din      <= '0;
      tx_wr_en    <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_wr_en    <= 1'b0;
      ack         <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !tx_busy) begin
            tx_din   <= req_data[{win, 3'b000} +: 8];
            tx_wr_en <= 1'b1;
            ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            grant_id <= win;
            ptr      <= (win == GW'(N_REQ-1)) ? '0 : win + 1'b1;
            busy     <= 1'b1;
            state    <= STROBE;
          end
        end
        STROBE: begin
          cnt   <= '0;
          state <= tx_busy ? WAIT_DONE : WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT-1)) begin
            // Transmitter never accepted the byte; drop it, the ack is already out.
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int T     = 16;
  localparam int FRAME = 4;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  ack;
  logic [1:0]    grant_id;
  logic [7:0]    tx_din;
  logic          tx_wr_en;
  logic          tx_busy;
  logic          busy;
  logic          err_timeout;

  logic auto_mode, man_busy, model_busy, auto_drop, prev_wr;
  int   model_cnt;
  int   errors, checks, strobes, errs_seen, cyc, wr_cyc, err_cyc, s0, e0;
  exp_t exp_q[$];

  assign tx_busy = auto_mode ? model_busy : man_busy;

  always #5 pclk = ~pclk;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(T)) dut (
    .pclk(pclk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // One clock; outputs are sampled on the falling edge, then the transmitter model advances.
  task automatic tick();
    exp_t e;
    @(posedge pclk);
    @(negedge pclk);
    cyc++;
    if (tx_wr_en === 1'b1) begin
      strobes++;
      wr_cyc = cyc;
      chk(tx_busy, 0, "strobe_while_tx_busy");
      chk(prev_wr, 0, "wr_en_width");
      chk(32'(exp_q.size() != 0), 1, "strobe_expected");
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(tx_din, e.d, "tx_din");
        chk(grant_id, e.id, "grant_id");
        chk(ack, 1 << e.id, "ack_onehot");
      end
      if (auto_mode) begin
        model_busy = 1'b1;
        model_cnt  = FRAME;
      end
    end else begin
      if (ack !== '0) chk(ack, 0, "ack_without_strobe");
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) model_busy = 1'b0;
      end
    end
    if (err_timeout === 1'b1) begin
      errs_seen++;
      err_cyc = cyc;
    end
    if (auto_drop) req = req & ~ack;
    prev_wr = tx_wr_en;
  endtask

  task automatic wait_q(input int lim, input string tag);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
    chk(exp_q.size(), 0, tag);
  endtask

  task automatic wait_idle(input int lim, input string tag);
    for (int i = 0; i < lim && !(busy === 1'b0 && tx_busy === 1'b0); i++) tick();
    chk(busy, 0, tag);
  endtask

  task automatic chk_cleared(input string tag);
    chk(ack, 0, {tag, "_ack"});
    chk(grant_id, 0, {tag, "_grant_id"});
    chk(tx_din, 0, {tag, "_tx_din"});
    chk(tx_wr_en, 0, {tag, "_tx_wr_en"});
    chk(busy, 0, {tag, "_busy"});
    chk(err_timeout, 0, {tag, "_err_timeout"});
  endtask

  initial begin
    errors = 0; checks = 0; strobes = 0; errs_seen = 0; cyc = 0; wr_cyc = 0; err_cyc = 0;
    req = '0; req_data = '0; rst_n = 1'b0;
    auto_mode = 1'b1; man_busy = 1'b0; model_busy = 1'b0; model_cnt = 0;
    auto_drop = 1'b1; prev_wr = 1'b0;
    tick();
    tick();
    chk_cleared("reset");
    rst_n = 1'b1;

    // Single requester 2
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    push(2, 8'hA5);
    tick();
    chk(strobes, 1, "single_latency");
    wait_idle(20, "single_idle");
    repeat (5) tick();
    chk(strobes, 1, "single_no_repeat");

    // Round robin from a fresh pointer, requests held through 8 grants
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    auto_drop = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i));
    wait_q(100, "rr_drain");
    req = '0;
    wait_idle(20, "rr_idle");

    // Pointer wrap: 3, then 0 before 2
    auto_drop = 1'b1;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b1000;
    push(3, 8'hD3);
    wait_q(10, "wrap_first");
    wait_idle(20, "wrap_idle1");
    req = 4'b0101;
    push(0, 8'hA0);
    push(2, 8'hC2);
    wait_q(40, "wrap_order");
    wait_idle(20, "wrap_idle2");

    // Busy timeout with tx_busy stuck low
    auto_mode = 1'b0;
    man_busy = 1'b0;
    e0 = errs_seen;
    req = 4'b0010;
    push(1, 8'hB1);
    wait_q(10, "to_strobe");
    req = req | 4'b0100;
    push(2, 8'hC2);
    for (int i = 0; i < 40 && errs_seen == e0; i++) tick();
    chk(err_cyc - wr_cyc, T + 1, "timeout_latency");
    chk(busy, 0, "timeout_busy_low");
    tick();
    chk(err_timeout, 0, "timeout_width");
    chk(exp_q.size(), 0, "grant_after_timeout");
    wait_idle(40, "timeout_idle2");
    chk(errs_seen - e0, 2, "timeout_count");

    // Transmitter busy when the request arrives
    man_busy = 1'b1;
    req = 4'b0001;
    s0 = strobes;
    repeat (5) tick();
    chk(strobes, s0, "busy_start_hold");
    push(0, 8'hA0);
    man_busy = 1'b0;
    tick();
    chk(exp_q.size(), 0, "busy_start_release");
    man_busy = 1'b1;
    tick();
    tick();
    man_busy = 1'b0;
    wait_idle(10, "busy_start_idle");

    // Reset during WAIT_DONE; pointer must restart at 0
    auto_mode = 1'b1;
    auto_drop = 1'b0;
    req_data = {8'h00, 8'h77, 8'h00, 8'h55};
    req = 4'b0001;
    push(0, 8'h55);
    wait_q(10, "rst_first");
    req = 4'b0101;
    req_data[7:0] = 8'h66;
    tick();
    tick();
    man_busy = 1'b1;
    auto_mode = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_cleared("midreset");
    s0 = strobes;
    repeat (4) tick();
    chk(strobes, s0, "midreset_hold");
    auto_drop = 1'b1;
    push(0, 8'h66);
    man_busy = 1'b0;
    tick();
    chk(exp_q.size(), 0, "midreset_ptr0_grant");
    man_busy = 1'b1;
    tick();
    man_busy = 1'b0;
    auto_mode = 1'b1;
    push(2, 8'h77);
    wait_q(30, "midreset_second");
    wait_idle(20, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
